// File: rtl/mcm_pkg.sv
// mcm_pkg: shared constants and stack frame type for the chain-multiplier traceback
package mcm_pkg;
    localparam int DIM    = 31;
    localparam int MAXN   = 30;
    localparam int SDEPTH = 64;
    localparam int AW     = 10;
    localparam int IW     = 8;
    localparam logic [1:0] TOK_MAT   = 2'd0;
    localparam logic [1:0] TOK_OPEN  = 2'd1;
    localparam logic [1:0] TOK_CLOSE = 2'd2;
    localparam logic K_SPAN  = 1'b0;
    localparam logic K_CLOSE = 1'b1;
    typedef struct packed {
        logic          kind;
        logic [IW-1:0] i;
        logic [IW-1:0] j;
    } frame_t;
endpackage

// File: rtl/tb_stack.sv
// tb_stack: SDEPTH-deep synchronous LIFO of traceback frames
module tb_stack import mcm_pkg::*; (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   push,
    input  logic   pop,
    input  frame_t din,
    output frame_t top,
    output logic   empty,
    output logic   full
);
    localparam int CW = $clog2(SDEPTH) + 1;
    frame_t mem_q [SDEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    // next occupancy; clear wins, overflowing pushes and underflowing pops are dropped
    always_comb cnt_d = clr ? '0 : (push && !full) ? cnt_q + 1'b1 : (pop && !empty) ? cnt_q - 1'b1 : cnt_q;
    // occupancy register with active-low synchronous reset
    always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
    // frame storage needs no reset; only entries below cnt_q are ever read
    always_ff @(posedge clk) if (push && !full && !clr) mem_q[cnt_q[CW-2:0]] <= din;
    assign top   = mem_q[cnt_q[CW-2:0] - 1'b1];
    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(SDEPTH);
endmodule

// File: rtl/paren_traceback.sv
// paren_traceback: walks the split table from (1,n) and streams the optimal parenthesization
module paren_traceback import mcm_pkg::*; (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    n,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_data,
    output logic          tok_valid,
    input  logic          tok_ready,
    output logic [1:0]    tok_type,
    output logic [7:0]    tok_idx,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {S_IDLE, S_POP, S_EMIT, S_RD, S_WAIT, S_PUSH, S_DONE, S_ERR} state_t;
    state_t state_q, state_d;
    logic tok_valid_q, tok_valid_d, pend_q, pend_d, rd_en_q, rd_en_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0] tok_type_q, tok_type_d, pc_q, pc_d;
    logic [IW-1:0] tok_idx_q, tok_idx_d, pi_q, pi_d, pj_q, pj_d, k_q, k_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic push, pop, empty, full;
    frame_t din, top;
    tb_stack u_stack (
        .clk(clk), .rst(rst), .clr(state_q == S_ERR), .push(push), .pop(pop),
        .din(din), .top(top), .empty(empty), .full(full)
    );
    // next-state, token and stack-control decode for the traceback walk
    always_comb begin
        state_d     = state_q;
        tok_valid_d = tok_valid_q;
        tok_type_d  = tok_type_q;
        tok_idx_d   = tok_idx_q;
        pend_d      = pend_q;
        pi_d        = pi_q;
        pj_d        = pj_q;
        k_d         = k_q;
        pc_d        = pc_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        push        = 1'b0;
        pop         = 1'b0;
        din         = '0;
        case (state_q)
            S_IDLE: if (start) begin
                if (n == '0 || n > IW'(MAXN)) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    push    = 1'b1;
                    din     = '{kind: K_SPAN, i: IW'(1), j: n};
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_POP;
                end
            end
            S_POP: if (empty) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                pop         = 1'b1;
                tok_valid_d = 1'b1;
                tok_type_d  = top.kind == K_CLOSE ? TOK_CLOSE : top.i == top.j ? TOK_MAT : TOK_OPEN;
                tok_idx_d   = (top.kind == K_SPAN && top.i == top.j) ? top.i : '0;
                pend_d      = top.kind == K_SPAN && top.i != top.j;
                pi_d        = top.i;
                pj_d        = top.j;
                state_d     = S_EMIT;
            end
            S_EMIT: if (tok_ready) begin
                tok_valid_d = 1'b0;
                tok_type_d  = '0;
                tok_idx_d   = '0;
                rd_en_d     = pend_q;
                rd_addr_d   = AW'(pj_q) * AW'(DIM) + AW'(pi_q);
                state_d     = pend_q ? S_RD : S_POP;
            end
            S_RD: state_d = S_WAIT;
            S_WAIT: begin
                k_d  = rd_data[7:0];
                pc_d = '0;
                if (rd_data[31:8] != '0 || rd_data[7:0] < pi_q || rd_data[7:0] >= pj_q) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else state_d = S_PUSH;
            end
            S_PUSH: if (full) begin
                state_d = S_ERR;
                err_d   = 1'b1;
                busy_d  = 1'b0;
            end else begin
                push     = 1'b1;
                din.kind = pc_q == 2'd0 ? K_CLOSE : K_SPAN;
                din.i    = pc_q == 2'd1 ? k_q + 1'b1 : pi_q;
                din.j    = pc_q == 2'd2 ? k_q : pj_q;
                pc_d     = pc_q + 2'd1;
                state_d  = pc_q == 2'd2 ? S_POP : S_PUSH;
            end
            S_DONE: state_d = S_IDLE;
            S_ERR: begin
                tok_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    // state and registered outputs with active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            tok_valid_q <= 1'b0;
            tok_type_q  <= '0;
            tok_idx_q   <= '0;
            pend_q      <= 1'b0;
            pi_q        <= '0;
            pj_q        <= '0;
            k_q         <= '0;
            pc_q        <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tok_valid_q <= tok_valid_d;
            tok_type_q  <= tok_type_d;
            tok_idx_q   <= tok_idx_d;
            pend_q      <= pend_d;
            pi_q        <= pi_d;
            pj_q        <= pj_d;
            k_q         <= k_d;
            pc_q        <= pc_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign tok_valid = tok_valid_q;
    assign tok_type  = tok_type_q;
    assign tok_idx   = tok_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule
